// File: rtl/div_55.sv
// div_55 -- odd-ratio clock divider, clk_div = clk / DIV_N at 50% duty.
//
// Two mirrored counter/phase pairs run on opposite edges of clk; OR-ing the
// half-cycle-offset phases stretches the high time by half a clk period,
// giving an exact 50% duty for odd DIV_N.
//
// Optional macro DIV_EVEN_EN: also accept even DIV_N. For even DIV_N only the
// rising-edge pair is used (H = DIV_N/2), and the falling-edge pair is held 0.
//
// Ports:
//   clk        in   source clock, both edges used
//   rst_n      in   asynchronous active-low reset
//   clk_div    out  divided clock (combinational OR of the two phases)
//   cnt1_r     out  rising-edge counter, 0..DIV_N-1
//   cnt2_r     out  falling-edge counter, 0..DIV_N-1
//   clk_div1_r out  rising-edge phase register
//   clk_div2_r out  falling-edge phase register
`timescale 1ns/1ps
module div_55 #(
    parameter int unsigned DIV_N = 55,
    parameter int unsigned CW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          clk_div,
    output logic [CW-1:0] cnt1_r,
    output logic [CW-1:0] cnt2_r,
    output logic          clk_div1_r,
    output logic          clk_div2_r
);

`ifdef DIV_EVEN_EN
    localparam bit EVEN_OK = 1'b1;
`else
    localparam bit EVEN_OK = 1'b0;
`endif

    localparam bit            IS_EVEN = (DIV_N % 2) == 0;
    localparam int unsigned   H       = IS_EVEN ? DIV_N / 2 : (DIV_N - 1) / 2;
    localparam logic [CW-1:0] LAST    = CW'(DIV_N - 1);
    localparam logic [CW-1:0] HCMP    = CW'(H);

    // Elaboration-time legality check of the configuration
    if ((IS_EVEN && !EVEN_OK) || (DIV_N < 3) || ((64'd1 << CW) < 64'(DIV_N))) begin : g_param_err
        $error("div_55: illegal configuration DIV_N=%0d CW=%0d", DIV_N, CW);
    end

    // Wrap on >= LAST so a corrupted (out-of-range) count recovers in one edge
    logic [CW-1:0] cnt1_nxt;
    assign cnt1_nxt = (cnt1_r >= LAST) ? '0 : cnt1_r + CW'(1);

    // Rising-edge counter/phase pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1_r     <= '0;
            clk_div1_r <= 1'b0;
        end else begin
            cnt1_r     <= cnt1_nxt;
            clk_div1_r <= (cnt1_nxt < HCMP);
        end
    end

    if (IS_EVEN) begin : g_even
        // Even ratio: the rising-edge phase alone is already 50% duty
        assign cnt2_r     = '0;
        assign clk_div2_r = 1'b0;
        assign clk_div    = clk_div1_r;
    end else begin : g_odd
        logic [CW-1:0] cnt2_nxt;
        assign cnt2_nxt = (cnt2_r >= LAST) ? '0 : cnt2_r + CW'(1);

        // Falling-edge counter/phase pair, trails the rising pair by half a period
        always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt2_r     <= '0;
                clk_div2_r <= 1'b0;
            end else begin
                cnt2_r     <= cnt2_nxt;
                clk_div2_r <= (cnt2_nxt < HCMP);
            end
        end

        // OR extends the high phase by the half-period offset
        assign clk_div = clk_div1_r | clk_div2_r;
    end

endmodule

// File: tb/tb_div_55.sv
// tb_div_55 -- scoreboard bench for div_55.
// A driver pushes the expected register state on every clk edge (and on reset
// assertion); a monitor pops and compares 1 ns later. A sequencer applies the
// reset pattern and measures clk_div high/low/period times.
`timescale 1ns/1ps
module tb_div_55;

`ifdef DIV_EVEN_EN
    localparam int unsigned N    = 10;
    localparam int unsigned CWB  = 4;
    localparam int unsigned EVEN = 1;
`else
    localparam int unsigned N    = 55;
    localparam int unsigned CWB  = 6;
    localparam int unsigned EVEN = 0;
`endif
    localparam int unsigned HB     = (EVEN != 0) ? N / 2 : (N - 1) / 2;
    localparam real         T_HIGH = (EVEN != 0) ? 5.0 * N : 10.0 * HB + 5.0;
    localparam real         T_PER  = 10.0 * N;
    localparam real         T_LOW  = T_PER - T_HIGH;
    localparam int unsigned MID    = (N > 40) ? 40 : N - 3;

    typedef struct {
        string           tag;
        logic [CWB-1:0]  c1;
        logic [CWB-1:0]  c2;
        logic            d1;
        logic            d2;
        logic            dv;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned np    = 0;   // posedges seen since last reset release
    int unsigned nn    = 0;   // negedges seen since last reset release
    bit          found;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           clk_div;
    logic [CWB-1:0] cnt1_r;
    logic [CWB-1:0] cnt2_r;
    logic           clk_div1_r;
    logic           clk_div2_r;

    div_55 #(.DIV_N(N), .CW(CWB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_div    (clk_div),
        .cnt1_r     (cnt1_r),
        .cnt2_r     (cnt2_r),
        .clk_div1_r (clk_div1_r),
        .clk_div2_r (clk_div2_r)
    );

    always #5 clk = ~clk;

    // Closed-form expectation: after k edges the count is k mod N and the
    // phase is high for the first HB counts of each cycle.
    function automatic exp_t model(input string tag);
        exp_t        e;
        int unsigned p = np % N;
        int unsigned f = nn % N;
        e.tag = tag;
        e.c1  = CWB'(p);
        e.d1  = (np != 0) && (p < HB);
        if (EVEN != 0) begin
            e.c2 = '0;
            e.d2 = 1'b0;
            e.dv = e.d1;
        end else begin
            e.c2 = CWB'(f);
            e.d2 = (nn != 0) && (f < HB);
            e.dv = e.d1 | e.d2;
        end
        return e;
    endfunction

    // Driver: expected state after every clk edge
    initial forever begin
        @(posedge clk or negedge clk);
        if (rst_n) begin
            if (clk) np++;
            else     nn++;
        end
        q.push_back(model(rst_n ? "run" : "reset_hold"));
    end

    // Monitor: compare every queued expectation shortly after the event
    initial forever begin
        @(posedge clk or negedge clk or negedge rst_n);
        #1;
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            n_vec++;
            if ({cnt1_r, cnt2_r, clk_div1_r, clk_div2_r, clk_div} !==
                {mon_e.c1, mon_e.c2, mon_e.d1, mon_e.d2, mon_e.dv}) begin
                n_err++;
                $display("FAIL %s @%0t: got c1=%0d c2=%0d d1=%b d2=%b div=%b, want c1=%0d c2=%0d d1=%b d2=%b div=%b",
                         mon_e.tag, $time, cnt1_r, cnt2_r, clk_div1_r, clk_div2_r, clk_div,
                         mon_e.c1, mon_e.c2, mon_e.d1, mon_e.d2, mon_e.dv);
            end
        end
    end

    // Poll (from a half-ns offset) until clk_div reaches lvl, bounded
    task automatic wait_lvl(input logic lvl, output realtime t);
        bit ok = 1'b0;
        for (int i = 0; i < int'(N) * 10 + 20 && !ok; i++) begin
            #1;
            if (clk_div === lvl) ok = 1'b1;
        end
        t = $realtime;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_clk_div @%0t: clk_div never reached %b", $time, lvl);
        end
    endtask

    task automatic measure(input int nper, input string tag);
        realtime t0, t1, t2, tx;
        @(posedge clk);
        #0.5;
        wait_lvl(1'b0, tx);
        wait_lvl(1'b1, t0);
        for (int i = 0; i < nper; i++) begin
            wait_lvl(1'b0, t1);
            wait_lvl(1'b1, t2);
            n_vec++;
            if ((t1 - t0) > T_HIGH + 0.01 || (t1 - t0) < T_HIGH - 0.01) begin
                n_err++;
                $display("FAIL %s_high[%0d]: got %0.1f ns, want %0.1f ns", tag, i, t1 - t0, T_HIGH);
            end
            n_vec++;
            if ((t2 - t1) > T_LOW + 0.01 || (t2 - t1) < T_LOW - 0.01) begin
                n_err++;
                $display("FAIL %s_low[%0d]: got %0.1f ns, want %0.1f ns", tag, i, t2 - t1, T_LOW);
            end
            t0 = t2;
        end
    endtask

    // Sequencer
    initial begin
        rst_n = 1'b0;
        #132;
        rst_n = 1'b1;
        #600;
        measure(10, "steady");

        // Mid-operation reset between edges once the rising count reaches MID
        found = 1'b0;
        for (int i = 0; i < int'(N) * 4 && !found; i++) begin
            @(posedge clk);
            #2;
            if ((np % N) == MID) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL mid_rst_sync: count %0d not reached", MID);
        end else begin
            rst_n = 1'b0;
            np    = 0;
            nn    = 0;
            q.push_back(model("mid_rst"));
            #20;
            rst_n = 1'b1;
            #600;
            measure(3, "after_rst");
        end
        #20;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
